// File: rtl/vga_pkg.sv
// Shared constants, enums and cursor clamp helpers for the VGA text console.
// Used by the writer, its address mapper and the scan-out side.
package vga_pkg;

    localparam int COLS   = 96;
    localparam int ROWS   = 32;
    localparam int ADDR_W = 12;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;

    localparam logic [7:0] BLANK_CH    = 8'd32;
    localparam logic [7:0] BLANK_COLOR = 8'd0;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        OP_PUT    = 2'd0,
        OP_NL     = 2'd1,
        OP_CLR    = 2'd2,
        OP_SETCUR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_ALL,
        ST_CLR_ROW
    } state_e;

    // Out-of-range cursor requests saturate to the last column/row.
    function automatic logic [COL_W-1:0] clampCol(input logic [7:0] c);
        return (c > 8'(COLS - 1)) ? LAST_COL : c[COL_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] clampRow(input logic [7:0] r);
        return (r > 8'(ROWS - 1)) ? LAST_ROW : r[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// Command and buffer-write bundle of the text writer.
// The slave side is the writer; the master side drives commands and observes writes.
interface vga_text_writer_if;
    import vga_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [7:0]        in_ch;
    logic [7:0]        in_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_ch;
    logic [7:0]        wr_color;
    logic [COL_W-1:0]  cur_x;
    logic [ROW_W-1:0]  cur_y;
    logic              busy;

    modport slave (
        input  in_valid, in_op, in_ch, in_color,
        output in_ready, wr_en, wr_addr, wr_ch, wr_color, cur_x, cur_y, busy
    );

    modport master (
        output in_valid, in_op, in_ch, in_color,
        input  in_ready, wr_en, wr_addr, wr_ch, wr_color, cur_x, cur_y, busy
    );

endinterface

// File: rtl/vga_rc2addr.sv
// Combinational row/column to character-buffer address (row*96 + col).
// The multiply is built from two shifts so it maps onto plain adders.
module vga_rc2addr
    import vga_pkg::*;
(
    input  logic [ROW_W-1:0]  row_i,
    input  logic [COL_W-1:0]  col_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] rowExt;
    logic [ADDR_W-1:0] colExt;

    assign rowExt = {{(ADDR_W - ROW_W){1'b0}}, row_i};
    assign colExt = {{(ADDR_W - COL_W){1'b0}}, col_i};
    assign addr_o = (rowExt << 6) + (rowExt << 5) + colExt;

endmodule

// File: rtl/vga_text_writer.sv
// Console command engine: owns the cursor, wrapping and clears, and emits one
// registered buffer-cell write per cycle on the write port.
module vga_text_writer
    import vga_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    vga_text_writer_if.slave bus
);

    state_e            state_q, state_d;
    logic [COL_W-1:0]  curX_q, curX_d;
    logic [ROW_W-1:0]  curY_q, curY_d;
    logic [COL_W-1:0]  fillCol_q, fillCol_d;
    logic [ROW_W-1:0]  fillRow_q, fillRow_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrCh_q, wrCh_d;
    logic [7:0]        wrColor_q, wrColor_d;

    logic              accept;
    logic [ROW_W-1:0]  nextRow;
    logic [ROW_W-1:0]  mapRow;
    logic [COL_W-1:0]  mapCol;
    logic [ADDR_W-1:0] mapAddr;

    assign accept  = bus.in_valid && (state_q == ST_IDLE);
    assign nextRow = (curY_q == LAST_ROW) ? '0 : curY_q + 1'b1;

    // One mapper serves the cursor cell in IDLE and the fill position while clearing.
    assign mapRow = (state_q == ST_CLR_ALL) ? fillRow_q : curY_q;
    assign mapCol = (state_q == ST_IDLE)    ? curX_q    : fillCol_q;

    vga_rc2addr u_rc2addr (
        .row_i  (mapRow),
        .col_i  (mapCol),
        .addr_o (mapAddr)
    );

    always_comb begin
        state_d   = state_q;
        curX_d    = curX_q;
        curY_d    = curY_q;
        fillCol_d = fillCol_q;
        fillRow_d = fillRow_q;
        wrEn_d    = 1'b0;
        wrAddr_d  = wrAddr_q;
        wrCh_d    = wrCh_q;
        wrColor_d = wrColor_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(bus.in_op))
                        OP_PUT: begin
                            wrEn_d    = 1'b1;
                            wrAddr_d  = mapAddr;
                            wrCh_d    = bus.in_ch;
                            wrColor_d = bus.in_color;
                            if (curX_q == LAST_COL) begin
                                curX_d    = '0;
                                curY_d    = nextRow;
                                fillCol_d = '0;
                                state_d   = ST_CLR_ROW;
                            end else begin
                                curX_d = curX_q + 1'b1;
                            end
                        end
                        OP_NL: begin
                            curX_d    = '0;
                            curY_d    = nextRow;
                            fillCol_d = '0;
                            state_d   = ST_CLR_ROW;
                        end
                        OP_CLR: begin
                            curX_d    = '0;
                            curY_d    = '0;
                            fillCol_d = '0;
                            fillRow_d = '0;
                            state_d   = ST_CLR_ALL;
                        end
                        OP_SETCUR: begin
                            curX_d = clampCol(bus.in_ch);
                            curY_d = clampRow(bus.in_color);
                        end
                    endcase
                end
            end
            ST_CLR_ROW: begin
                wrEn_d    = 1'b1;
                wrAddr_d  = mapAddr;
                wrCh_d    = BLANK_CH;
                wrColor_d = BLANK_COLOR;
                if (fillCol_q == LAST_COL) begin
                    fillCol_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    fillCol_d = fillCol_q + 1'b1;
                end
            end
            ST_CLR_ALL: begin
                wrEn_d    = 1'b1;
                wrAddr_d  = mapAddr;
                wrCh_d    = BLANK_CH;
                wrColor_d = BLANK_COLOR;
                if (fillCol_q == LAST_COL) begin
                    fillCol_d = '0;
                    if (fillRow_q == LAST_ROW) begin
                        fillRow_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        fillRow_d = fillRow_q + 1'b1;
                    end
                end else begin
                    fillCol_d = fillCol_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset restarts the full-screen fill from address 0, aborting any clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLR_ALL;
            curX_q    <= '0;
            curY_q    <= '0;
            fillCol_q <= '0;
            fillRow_q <= '0;
            wrEn_q    <= 1'b0;
            wrAddr_q  <= '0;
            wrCh_q    <= '0;
            wrColor_q <= '0;
        end else begin
            state_q   <= state_d;
            curX_q    <= curX_d;
            curY_q    <= curY_d;
            fillCol_q <= fillCol_d;
            fillRow_q <= fillRow_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrCh_q    <= wrCh_d;
            wrColor_q <= wrColor_d;
        end
    end

    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.wr_en    = wrEn_q;
    assign bus.wr_addr  = wrAddr_q;
    assign bus.wr_ch    = wrCh_q;
    assign bus.wr_color = wrColor_q;
    assign bus.cur_x    = curX_q;
    assign bus.cur_y    = curY_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: command table with expected cursor/ready, plus a
// scoreboard of expected buffer writes built from an independent cursor model.
module tb_vga_text_writer;
    import vga_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_text_writer_if bus();

    vga_text_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [7:0]  color;
    } wr_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] ch;
        logic [7:0] color;
        int         expX;
        int         expY;
        int         expReady;
    } vec_t;

    wr_t  expQ[$];
    vec_t tbl[13];
    int   nVec    = 0;
    int   nMiss   = 0;
    int   nWrites = 0;
    int   mX      = 0;
    int   mY      = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic void pushWrite(input int addr, input int ch, input int color);
        wr_t w;
        w.addr  = 12'(addr);
        w.ch    = 8'(ch);
        w.color = 8'(color);
        expQ.push_back(w);
    endfunction

    function automatic void pushBlankRow(input int r);
        for (int c = 0; c < 96; c++) pushWrite(r * 96 + c, 32, 0);
    endfunction

    function automatic void pushFullFill();
        for (int r = 0; r < 32; r++) pushBlankRow(r);
    endfunction

    function automatic void lineAdvance();
        mX = 0;
        mY = (mY + 1) % 32;
        pushBlankRow(mY);
    endfunction

    // Reference behaviour of one accepted command, written from the console's point of view.
    function automatic void modelCmd(input logic [1:0] op, input int ch, input int color);
        case (op)
            2'd0: begin
                pushWrite(mY * 96 + mX, ch, color);
                if (mX == 95) lineAdvance();
                else mX = mX + 1;
            end
            2'd1: lineAdvance();
            2'd2: begin
                mX = 0;
                mY = 0;
                pushFullFill();
            end
            default: begin
                mX = (ch > 95) ? 95 : ch;
                mY = (color > 31) ? 31 : color;
            end
        endcase
    endfunction

    // Scoreboard: every write the DUT makes must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en === 1'b1) begin
            wr_t e;
            nWrites++;
            nVec++;
            if (expQ.size() == 0) begin
                nMiss++;
                $display("[TB] FAIL unexpected_write: got addr %0d ch %0d color %0d, required no write",
                         bus.wr_addr, bus.wr_ch, bus.wr_color);
            end else begin
                e = expQ.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_ch !== e.ch || bus.wr_color !== e.color) begin
                    nMiss++;
                    $display("[TB] FAIL write: got addr %0d ch %0d color %0d, required addr %0d ch %0d color %0d",
                             bus.wr_addr, bus.wr_ch, bus.wr_color, e.addr, e.ch, e.color);
                end
            end
        end
    end

    task automatic waitReady(input int maxCyc, input string name, output int cyc);
        cyc = 0;
        while (cyc < maxCyc) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) return;
            cyc++;
        end
        nVec++;
        nMiss++;
        $display("[TB] FAIL %s: in_ready still 0 after %0d cycles, required 1", name, maxCyc);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] ch, input logic [7:0] color);
        int cyc;
        waitReady(4000, "ready_timeout", cyc);
        bus.in_op    = op;
        bus.in_ch    = ch;
        bus.in_color = color;
        bus.in_valid = 1'b1;
        modelCmd(op, int'(ch), int'(color));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic checkCursor(input string name, input int x, input int y, input int rdy);
        checkOutput({name, "_cur_x"}, int'(bus.cur_x), x);
        checkOutput({name, "_cur_y"}, int'(bus.cur_y), y);
        checkOutput({name, "_in_ready"}, int'(bus.in_ready), rdy);
        checkOutput({name, "_busy"}, int'(bus.busy), 1 - rdy);
    endtask

    initial begin
        #1_000_000;
        nMiss++;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin
        int cyc;

        tbl[0]  = '{2'd0, 8'd66,  8'd7,   2,  0, 1};
        tbl[1]  = '{2'd3, 8'd95,  8'd3,   95, 3, 1};
        tbl[2]  = '{2'd0, 8'd66,  8'd1,   0,  4, 0};
        tbl[3]  = '{2'd3, 8'd200, 8'd99,  95, 31, 1};
        tbl[4]  = '{2'd1, 8'd0,   8'd0,   0,  0, 0};
        tbl[5]  = '{2'd3, 8'd10,  8'd5,   10, 5, 1};
        tbl[6]  = '{2'd0, 8'd255, 8'd200, 11, 5, 1};
        tbl[7]  = '{2'd1, 8'd9,   8'd9,   0,  6, 0};
        tbl[8]  = '{2'd3, 8'd94,  8'd31,  94, 31, 1};
        tbl[9]  = '{2'd0, 8'd1,   8'd3,   95, 31, 1};
        tbl[10] = '{2'd0, 8'd2,   8'd4,   0,  0, 0};
        tbl[11] = '{2'd3, 8'd96,  8'd32,  95, 31, 1};
        tbl[12] = '{2'd3, 8'd40,  8'd2,   40, 2, 1};

        bus.in_valid = 1'b0;
        bus.in_op    = 2'd0;
        bus.in_ch    = 8'd0;
        bus.in_color = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_wr_en", int'(bus.wr_en), 0);
        checkOutput("reset_wr_addr", int'(bus.wr_addr), 0);
        checkCursor("reset", 0, 0, 0);

        pushFullFill();
        @(negedge clk);
        rst_n = 1'b1;
        waitReady(4000, "reset_fill_ready", cyc);
        nVec++;
        if (!(cyc inside {[3071:3072]})) begin
            nMiss++;
            $display("[TB] FAIL reset_fill_length: got %0d cycles to ready, required 3071..3072", cyc);
        end
        @(negedge clk);
        checkOutput("reset_fill_writes", nWrites, 3072);
        checkOutput("reset_fill_drained", expQ.size(), 0);
        checkOutput("after_fill_wr_en", int'(bus.wr_en), 0);
        checkCursor("after_fill", 0, 0, 1);

        applyStimulus(2'd0, 8'd65, 8'd2);
        checkCursor("put_first", 1, 0, 1);
        @(negedge clk);
        checkOutput("put_latency_wr_en", int'(bus.wr_en), 1);
        checkOutput("put_latency_wr_addr", int'(bus.wr_addr), 0);
        checkOutput("put_latency_wr_ch", int'(bus.wr_ch), 65);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].op, tbl[i].ch, tbl[i].color);
            checkCursor($sformatf("vec%0d", i), tbl[i].expX, tbl[i].expY, tbl[i].expReady);
        end

        // Back-to-back PUTs with in_valid held high for six cycles.
        waitReady(4000, "b2b_ready", cyc);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_op    = 2'd0;
            bus.in_ch    = 8'(100 + i);
            bus.in_color = 8'(i);
            modelCmd(2'd0, 100 + i, i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkCursor("b2b", 46, 2, 1);

        // CLEAR interrupted by reset partway through the fill.
        applyStimulus(2'd2, 8'd0, 8'd0);
        checkCursor("clear_start", 0, 0, 0);
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1 && bus.wr_addr === 12'd1000) break;
            cyc++;
        end
        if (cyc >= 2000) begin
            nVec++;
            nMiss++;
            $display("[TB] FAIL clear_reach_1000: address 1000 not written within 2000 cycles, required written");
        end
        #1;
        rst_n = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("abort_wr_en", int'(bus.wr_en), 0);
        checkCursor("abort", 0, 0, 0);
        mX = 0;
        mY = 0;
        pushFullFill();
        @(negedge clk);
        rst_n = 1'b1;
        waitReady(4000, "refill_ready", cyc);
        @(negedge clk);
        checkOutput("refill_drained", expQ.size(), 0);
        checkCursor("refill_done", 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
- Writer side of the VGA character/colour buffer: turns a stream of console commands from the CPU's MMIO path into single-cell writes on the buffer's write port.
- The VGA scan-out reads the same buffer at address 96*y+x, using 8-bit glyph codes and 8-bit colour codes.
- Owns the text cursor, line wrap, row clearing and full-screen clear, so software never computes buffer addresses.

Parameters:
- COLS, 96, characters per row (768 px / 8).
- ROWS, 32, character rows (512 px / 16).
- ADDR_W, 12, width of buffer address; must hold COLS*ROWS-1 = 3071.
- BLANK_CH, 32, glyph code written by clear operations (space).
- BLANK_COLOR, 0, colour code written by clear operations (black).

Ports:
- clk       in   1   system clock (VGA-domain clock shared with the buffer write port)
- rst_n     in   1   synchronous reset, active-low
- in_valid  in   1   command valid
- in_ready  out  1   block can accept a command this cycle
- in_op     in   2   0 PUT, 1 NEWLINE, 2 CLEAR, 3 SET_CURSOR
- in_ch     in   8   PUT: glyph code; SET_CURSOR: column
- in_color  in   8   PUT: colour code 0..7; SET_CURSOR: row
- wr_en     out  1   buffer write strobe
- wr_addr   out  12  buffer address = row*COLS + col
- wr_ch     out  8   glyph written
- wr_color  out  8   colour written
- cur_x     out  7   cursor column, 0..COLS-1
- cur_y     out  5   cursor row, 0..ROWS-1
- busy      out  1   a clear is in progress (equals ~in_ready)

Behaviour:
- Reset (rst_n low at a clk edge):
  - wr_en=0, wr_addr=0, wr_ch=0, wr_color=0, cur_x=0, cur_y=0, in_ready=0.
  - The FSM goes to CLR_ALL with its fill counter at 0. Any in-progress clear is aborted.
  - Buffer contents are not reset by this block beyond the fill it starts.
- States:
  - IDLE: in_ready=1.
  - CLR_ALL: in_ready=0.
  - CLR_ROW: in_ready=0.
- Handshake:
  - A command is accepted on an edge where in_valid && in_ready.
  - in_ready is combinational from state only, never from in_valid.
  - Non-accepted inputs are ignored.
- All write outputs are registered. A write caused by an accepted command appears on wr_* in the cycle after acceptance (latency 1). wr_en is high for exactly one cycle per cell written.
- PUT:
  - Writes (in_ch, in_color) at the current cursor; in_ch is passed through unmodified.
  - Then cur_x++. If cur_x was COLS-1, it performs a line advance instead.
- NEWLINE: line advance; no write to the current cell.
- Line advance:
  - cur_x=0, cur_y=(cur_y+1) mod ROWS, so row ROWS-1 wraps to row 0.
  - Then CLR_ROW fills the new row with BLANK_CH/BLANK_COLOR.
  - Wrap edge case: a PUT at column COLS-1 writes its cell in the acceptance+1 cycle, then the row clear follows.
- CLR_ROW:
  - Issues COLS consecutive writes at addresses row*COLS+0 .. row*COLS+COLS-1, one per cycle.
  - Returns to IDLE the cycle after the last write; in_ready is high in that cycle.
- CLEAR:
  - Sets the cursor to (0,0), then CLR_ALL writes addresses 0..COLS*ROWS-1 (3072 cycles), then IDLE.
- After reset, the CLR_ALL fill starts the first cycle rst_n is high; in_ready rises after 3072 writes.
- SET_CURSOR:
  - cur_x=min(in_ch, COLS-1), cur_y=min(in_color, ROWS-1).
  - No write and no row clear.
- Cursor outputs update on the edge that accepts the command, and for line advances at the start of CLR_ROW. A clear never changes the cursor after its start.
- Address arithmetic:
  - row*96 computed as (row<<6)+(row<<5), zero-extended to ADDR_W, plus the column.
  - The result never exceeds 3071, so no overflow is possible.
- Colour codes above 7 are written as given; the renderer treats them as black.

Decomposition:
- Shared package vga_pkg:
  - COLS, ROWS, ADDR_W, BLANK_CH, BLANK_COLOR.
  - Enum for in_op (OP_PUT, OP_NL, OP_CLR, OP_SETCUR).
  - Colour-code enum (BLACK..WHITE, 0..7).
  - FSM state enum.
- One sub-module, vga_rc2addr: combinational row/column to address. It is shared by the PUT path and the fill counter, and is reusable by the scan-out side.

Test Plan:
- Reset released, in_valid=0 -> wr_en high for exactly 3072 cycles, addresses 0..3071, all wr_ch=32, wr_color=0; in_ready rises the next cycle; cursor (0,0).
- PUT ch=65 color=2 at (0,0) -> one cycle later wr_en=1, wr_addr=0, wr_ch=65, wr_color=2; cur_x=1; in_ready stays high.
- SET_CURSOR (95,3), then PUT ch=66 -> write at addr 383; cursor becomes (0,4); 96 blank writes at addrs 384..479; in_ready low during them.
- SET_CURSOR (200,99) -> cursor clamps to (95,31); then NEWLINE -> cursor (0,0), blank writes at addrs 0..95, no write at 3071.
- Back-to-back PUTs with in_valid held high in IDLE -> one write per cycle at consecutive addresses, no dropped or duplicated command.
- CLEAR accepted, rst_n pulsed low at fill address 1000 -> next cycle wr_en=0, cursor (0,0), state restarts CLR_ALL at address 0.
